fir_coef_ctrl: RTL and testbench
================================

Name: fir_coef_ctrl

Overview:
Coefficient configuration and sequencing controller for the symmetric FIR datapath. Accepts coefficient writes into a shadow bank over a valid/ready interface. On commit, it swaps the shadow bank into the active bank on the next sample boundary, flushes the filter, and masks output-valid until the delay line has refilled with samples filtered by the new coefficients. It sits between the host/config logic and the filter's coefficient, flush and sample-enable inputs.

Parameters:
WIDTH, 16, coefficient and sample width (matches the codebase `width`)
NTAPS, 8, number of coefficients (1..64, need not be a power of 2)
ADDR_W, 3, coefficient address width; must satisfy 2^ADDR_W >= NTAPS
LATENCY, 2, filter pipeline latency in sample strobes, from input sample to output sample

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  config transaction valid
cfg_ready  out  1  controller can accept a config transaction
cfg_addr  in  ADDR_W  tap index to write
cfg_data  in  WIDTH  coefficient value, signed two's complement
cfg_commit  in  1  qualified by cfg_valid; marks the last write of a set and requests a swap
cfg_err  out  1  one-cycle pulse when a write to an address >= NTAPS is accepted
sample_strobe  in  1  one-cycle pulse per input sample (filter advance)
coef_bank  out  NTAPS*WIDTH  active coefficients; tap k occupies bits [k*WIDTH +: WIDTH]
filter_flush  out  1  one-cycle pulse clearing the filter delay line
busy  out  1  a swap is pending or a flush is in progress
out_valid  out  1  the filter output for the current sample is valid

Behaviour:
- Transaction: accepted when cfg_valid && cfg_ready on a rising clk edge.
  - In-range write: shadow[cfg_addr] <= cfg_data.
  - Out-of-range write (addr >= NTAPS): data dropped; cfg_err pulses high in the next cycle.
  - cfg_commit=1: the write is applied first, then the commit takes effect, so the committed set includes that write.
- FSM states:
  - IDLE: cfg_ready=1, busy=0. An accepted transaction with cfg_commit=1 -> WAIT_SWAP next cycle.
  - WAIT_SWAP: cfg_ready=0, busy=1. Waits for the first sample_strobe strictly after entry. A strobe in the same cycle as the commit handshake does not count.
    - On that strobe: active <= shadow (all NTAPS atomically, in the same edge), filter_flush=1 for exactly one cycle (the cycle after the strobe), fill counter <= NTAPS+LATENCY, -> FLUSH.
  - FLUSH: cfg_ready=0, busy=1, out_valid forced 0. Counter decrements on each sample_strobe.
    - When it decrements from 1 to 0 -> IDLE, and the primed flag is set.
- Edge cases:
  - coef_bank changes only on the swap edge, never mid-set.
  - Shadow bank retains its contents after a swap, so partial updates followed by commit are legal.
- out_valid: registered; high for exactly the one cycle after a sample_strobe when primed=1 and state is IDLE or WAIT_SWAP. Low otherwise.
  - While the swap is pending, output from the old coefficients remains valid.
  - A strobe on the FLUSH->IDLE transition edge does not produce out_valid.
- Reset (any cycle, including mid-FLUSH or WAIT_SWAP):
  - Shadow and active banks cleared to 0; state IDLE; counter 0; primed 0.
  - cfg_ready=1 in the first cycle after reset; cfg_err=0, filter_flush=0, busy=0, out_valid=0.
  - A pending swap is discarded.
  - out_valid stays 0 until the first commit's flush completes.
- Simultaneous events: reset has priority over everything. With cfg_ready=0, cfg_valid is ignored (no write, no cfg_err).
- Widths: no arithmetic on coefficients. Counter width is clog2(NTAPS+LATENCY+1).

Test Plan:
- Reset, then 5 strobes -> coef_bank=0, out_valid never high, cfg_ready=1, busy=0.
- Write taps 0..7 with values 1..8, commit on tap 7, then strobe -> swap on that strobe; coef_bank tap k = k+1; filter_flush pulses once; busy=1.
  - out_valid stays low for 10 strobes (NTAPS+LATENCY), then goes high one cycle after the 11th strobe; busy drops after the 10th strobe.
- Commit handshake in the same cycle as a strobe -> no swap on that strobe; swap on the next strobe; coef_bank unchanged until then.
- Write addr 0 = 0x7FFF with cfg_commit=1 only (other shadow taps hold 1..8 from the earlier test) -> after swap, tap0=0x7FFF and taps 1..7 = 2..8.
  - During WAIT_SWAP, out_valid keeps pulsing after each strobe.
- Attempted writes while busy (cfg_valid=1, addr 2, data 0x1234) -> cfg_ready=0, shadow tap2 unchanged. With a non-power-of-2 build (NTAPS=6, ADDR_W=3), a write to addr 6 -> cfg_err pulse, banks unchanged.
- Assert reset during FLUSH (counter = 4) -> next cycle: busy=0, out_valid=0, coef_bank=0; a later commit plus 10 strobes re-primes normally.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
// Coefficient shadow/active bank controller for the symmetric FIR datapath.
// A commit swaps the banks on the next sample, flushes the filter and masks out_valid until the filter refills.
module fir_coef_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NTAPS   = 8,
  parameter int ADDR_W  = 3,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [WIDTH-1:0]       cfg_data,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  input  logic                   sample_strobe,
  output logic [NTAPS*WIDTH-1:0] coef_bank,
  output logic                   filter_flush,
  output logic                   busy,
  output logic                   out_valid
);

  localparam int CNT_W = $clog2(NTAPS + LATENCY + 1);
  localparam logic [CNT_W-1:0] FILL_COUNT = CNT_W'(NTAPS + LATENCY);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SWAP = 2'd1;
  localparam logic [1:0] FLUSH     = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] fill_cnt;
  logic             primed;
  logic [WIDTH-1:0] shadow [NTAPS];
  logic [31:0]      addr_ext;
  logic             accept;
  logic             in_range;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign addr_ext  = 32'(cfg_addr);
  assign in_range  = addr_ext < $unsigned(NTAPS);

  // The write lands in the shadow bank on the same edge the commit moves us to WAIT_SWAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      primed       <= 1'b0;
      cfg_err      <= 1'b0;
      filter_flush <= 1'b0;
      out_valid    <= 1'b0;
      coef_bank    <= '0;
      for (int k = 0; k < NTAPS; k++) shadow[k] <= '0;
    end else begin
      cfg_err      <= accept && !in_range;
      filter_flush <= 1'b0;
      out_valid    <= sample_strobe && primed && (state == IDLE || state == WAIT_SWAP);
      for (int k = 0; k < NTAPS; k++) begin
        if (accept && addr_ext == 32'(k)) shadow[k] <= cfg_data;
      end
      case (state)
        IDLE: begin
          if (accept && cfg_commit) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (sample_strobe) begin
            for (int k = 0; k < NTAPS; k++) coef_bank[k*WIDTH +: WIDTH] <= shadow[k];
            filter_flush <= 1'b1;
            fill_cnt     <= FILL_COUNT;
            state        <= FLUSH;
          end
        end
        FLUSH: begin
          if (sample_strobe) begin
            fill_cnt <= fill_cnt - CNT_W'(1);
            if (fill_cnt == CNT_W'(1)) begin
              state  <= IDLE;
              primed <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: directed steps plus random traffic checked against a bank/fill model.
// A second NTAPS=6 instance covers out-of-range writes on a non-power-of-2 build.
module tb_fir_coef_ctrl;

  localparam int NTAPS = 8;
  localparam int LAT   = 2;

  logic         clk = 1'b0;
  logic         reset, cfg_valid, cfg_commit, sample_strobe;
  logic [2:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         cfg_ready, cfg_err, filter_flush, busy, out_valid;
  logic [127:0] coef_bank;

  logic         b_reset, b_cfg_valid, b_cfg_commit, b_sample_strobe;
  logic [2:0]   b_cfg_addr;
  logic [15:0]  b_cfg_data;
  logic         b_cfg_ready, b_cfg_err, b_filter_flush, b_busy, b_out_valid;
  logic [95:0]  b_coef_bank;

  int compared = 0;
  int failed   = 0;

  logic [15:0] m_shadow [NTAPS];
  logic [15:0] m_active [NTAPS];
  bit          m_pending, m_primed, exp_err, exp_flush, exp_ov;
  int          m_fill;

  always #5 clk = ~clk;

  fir_coef_ctrl #(.WIDTH(16), .NTAPS(NTAPS), .ADDR_W(3), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
    .sample_strobe(sample_strobe), .coef_bank(coef_bank), .filter_flush(filter_flush),
    .busy(busy), .out_valid(out_valid)
  );

  fir_coef_ctrl #(.WIDTH(16), .NTAPS(6), .ADDR_W(3), .LATENCY(LAT)) dut6 (
    .clk(clk), .reset(b_reset), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_commit(b_cfg_commit), .cfg_err(b_cfg_err),
    .sample_strobe(b_sample_strobe), .coef_bank(b_coef_bank), .filter_flush(b_filter_flush),
    .busy(b_busy), .out_valid(b_out_valid)
  );

  task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [127:0] exp_bank;
    bit idle_m;
    for (int k = 0; k < NTAPS; k++) exp_bank[k*16 +: 16] = m_active[k];
    idle_m = !m_pending && (m_fill == 0);
    checkValue("coef_bank", coef_bank, exp_bank);
    checkValue("cfg_ready", 128'(cfg_ready), 128'(idle_m));
    checkValue("busy", 128'(busy), 128'(!idle_m));
    checkValue("cfg_err", 128'(cfg_err), 128'(exp_err));
    checkValue("filter_flush", 128'(filter_flush), 128'(exp_flush));
    checkValue("out_valid", 128'(out_valid), 128'(exp_ov));
  endtask

  // One clock of stimulus; the model advances using the state it held before the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] a,
                               input logic [15:0] d, input logic c, input logic s);
    bit accept_m;
    reset = rst; cfg_valid = v; cfg_addr = a; cfg_data = d; cfg_commit = c; sample_strobe = s;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
      m_pending = 0; m_primed = 0; m_fill = 0;
      exp_err = 0; exp_flush = 0; exp_ov = 0;
    end else begin
      accept_m  = v && !m_pending && (m_fill == 0);
      exp_err   = accept_m && (int'(a) >= NTAPS);
      exp_flush = 0;
      exp_ov    = s && m_primed && (m_fill == 0);
      if (accept_m && int'(a) < NTAPS) m_shadow[a] = d;
      if (m_pending && s) begin
        m_active  = m_shadow;
        exp_flush = 1;
        m_fill    = NTAPS + LAT;
        m_pending = 0;
      end else if (m_fill > 0 && s) begin
        m_fill--;
        if (m_fill == 0) m_primed = 1;
      end
      if (accept_m && c) m_pending = 1;
    end
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd0, 16'd0, 0, 0);
  endtask

  task automatic strobeWithGap();
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    idleCycles($urandom_range(0, 2));
  endtask

  initial begin
    b_reset = 1; b_cfg_valid = 0; b_cfg_addr = 0; b_cfg_data = 0; b_cfg_commit = 0; b_sample_strobe = 0;

    // Reset, then strobes with no configuration: nothing becomes valid.
    applyStimulus(1, 0, 3'd0, 16'd0, 0, 0);
    applyStimulus(1, 0, 3'd0, 16'd0, 0, 0);
    for (int i = 0; i < 5; i++) strobeWithGap();

    for (int k = 0; k < NTAPS; k++) applyStimulus(0, 1, 3'(k), 16'(k + 1), (k == NTAPS - 1), 0);
    idleCycles(2);
    strobeWithGap();
    for (int k = 0; k < NTAPS; k++) checkValue("tap_k_plus_1", 128'(coef_bank[k*16 +: 16]), 128'(k + 1));
    for (int i = 0; i < NTAPS + LAT; i++) strobeWithGap();
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    checkValue("first_primed_valid", 128'(out_valid), 128'(1));

    // Commit coincident with a strobe, then blocked writes while busy.
    applyStimulus(0, 1, 3'd0, 16'h7FFF, 1, 1);
    checkValue("no_swap_same_cycle", 128'(coef_bank[15:0]), 128'(1));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'd2, 16'h1234, 0, 0);
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    checkValue("tap0_7fff", 128'(coef_bank[15:0]), 128'(16'h7FFF));
    checkValue("tap1_kept", 128'(coef_bank[31:16]), 128'(2));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'd2, 16'h1234, 0, 0);
    for (int i = 0; i < NTAPS + LAT; i++) strobeWithGap();
    applyStimulus(0, 1, 3'd7, 16'h00AA, 1, 0);
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    checkValue("tap2_not_overwritten", 128'(coef_bank[47:32]), 128'(3));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));

    // Reset in the middle of a flush, then re-prime.
    for (int i = 0; i < 40 && (m_pending || m_fill > 0); i++) applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    applyStimulus(0, 1, 3'd4, 16'($urandom), 1, 0);
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    for (int i = 0; i < 20 && m_fill != 4; i++) applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    checkValue("fill_reached_4", 128'(m_fill), 128'(4));
    applyStimulus(1, 0, 3'd0, 16'd0, 0, 1);
    checkValue("reset_bank_zero", coef_bank, 128'(0));
    checkValue("reset_not_busy", 128'(busy), 128'(0));
    applyStimulus(0, 1, 3'd5, 16'hBEEF, 1, 0);
    strobeWithGap();
    for (int i = 0; i < NTAPS + LAT; i++) strobeWithGap();
    applyStimulus(0, 0, 3'd0, 16'd0, 0, 1);
    checkValue("reprime_valid", 128'(out_valid), 128'(1));
    checkValue("reprime_tap5", 128'(coef_bank[95:80]), 128'(16'hBEEF));

    // Six-tap build: out-of-range writes flag cfg_err and never touch the banks.
    @(posedge clk); #1;
    b_reset = 0; b_cfg_valid = 1; b_cfg_addr = 3'd3; b_cfg_data = 16'h0C33;
    @(posedge clk); #1;
    checkValue("b_err_inrange", 128'(b_cfg_err), 128'(0));
    b_cfg_addr = 3'd6; b_cfg_data = 16'hDEAD;
    @(posedge clk); #1;
    checkValue("b_err_addr6", 128'(b_cfg_err), 128'(1));
    b_cfg_valid = 0;
    @(posedge clk); #1;
    checkValue("b_err_one_cycle", 128'(b_cfg_err), 128'(0));
    checkValue("b_bank_untouched", 128'(b_coef_bank), 128'(0));
    b_cfg_valid = 1; b_cfg_addr = 3'd7; b_cfg_commit = 1;
    @(posedge clk); #1;
    b_cfg_valid = 0; b_cfg_commit = 0;
    checkValue("b_err_addr7", 128'(b_cfg_err), 128'(1));
    checkValue("b_busy", 128'(b_busy), 128'(1));
    b_sample_strobe = 1;
    @(posedge clk); #1;
    b_sample_strobe = 0;
    checkValue("b_flush", 128'(b_filter_flush), 128'(1));
    checkValue("b_bank_swap", 128'(b_coef_bank), 128'(96'h0C33) << 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
